// File: rtl/parking_pkg.sv
// Shared types and sensor codes for the parking-lot occupancy controller.
// Sensor codes are {a, b} after polarity correction: 1 means the beam is broken.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EN_A  = 3'd1,
    EN_AB = 3'd2,
    EN_B  = 3'd3,
    EX_B  = 3'd4,
    EX_BA = 3'd5,
    EX_A  = 3'd6,
    WAIT  = 3'd7
  } gate_state_t;

  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_B    = 2'b01;
  localparam logic [1:0] AB_BOTH = 2'b11;

endpackage

// File: rtl/parking_gate_fsm.sv
// One gate: polarity fix, 2-flop synchronizer, A/B sequence decoder and
// registered entry/exit event pulses.
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter bit SENSOR_ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic entry_pulse,
  output logic exit_pulse,
  output logic gate_busy
);

  logic [1:0]  ab_pin;
  logic [1:0]  sync1_reg;
  logic [1:0]  sync2_reg;
  gate_state_t state_reg, state_next;
  logic        entry_reg, entry_next;
  logic        exit_reg, exit_next;

  assign ab_pin = {sensor_a, sensor_b} ^ {2{SENSOR_ACTIVE_LOW}};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_reg <= AB_NONE;
      sync2_reg <= AB_NONE;
      state_reg <= IDLE;
      entry_reg <= 1'b0;
      exit_reg  <= 1'b0;
    end else begin
      sync1_reg <= ab_pin;
      sync2_reg <= sync1_reg;
      state_reg <= state_next;
      entry_reg <= entry_next;
      exit_reg  <= exit_next;
    end
  end

  // Unlisted codes hold; a jump into the opposite direction's pattern parks in WAIT.
  always_comb begin
    state_next = state_reg;
    entry_next = 1'b0;
    exit_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (sync2_reg == AB_A)         state_next = EN_A;
        else if (sync2_reg == AB_B)    state_next = EX_B;
        else if (sync2_reg == AB_BOTH) state_next = WAIT;
      end
      EN_A: begin
        if (sync2_reg == AB_BOTH)      state_next = EN_AB;
        else if (sync2_reg == AB_NONE) state_next = IDLE;
        else if (sync2_reg == AB_B)    state_next = WAIT;
      end
      EN_AB: begin
        if (sync2_reg == AB_B)         state_next = EN_B;
        else if (sync2_reg == AB_A)    state_next = EN_A;
      end
      EN_B: begin
        if (sync2_reg == AB_NONE) begin
          state_next = IDLE;
          entry_next = 1'b1;
        end else if (sync2_reg == AB_BOTH) state_next = EN_AB;
        else if (sync2_reg == AB_A)        state_next = WAIT;
      end
      EX_B: begin
        if (sync2_reg == AB_BOTH)      state_next = EX_BA;
        else if (sync2_reg == AB_NONE) state_next = IDLE;
        else if (sync2_reg == AB_A)    state_next = WAIT;
      end
      EX_BA: begin
        if (sync2_reg == AB_A)         state_next = EX_A;
        else if (sync2_reg == AB_B)    state_next = EX_B;
      end
      EX_A: begin
        if (sync2_reg == AB_NONE) begin
          state_next = IDLE;
          exit_next  = 1'b1;
        end else if (sync2_reg == AB_BOTH) state_next = EX_BA;
        else if (sync2_reg == AB_B)        state_next = WAIT;
      end
      WAIT: begin
        if (sync2_reg == AB_NONE)      state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign entry_pulse = entry_reg;
  assign exit_pulse  = exit_reg;
  assign gate_busy   = (state_reg != IDLE);

endmodule

// File: rtl/parking_lot_ctrl.sv
// Multi-gate parking-lot controller: per-gate sequence decoders feeding a
// shared clamped occupancy counter with registered status and sticky errors.
module parking_lot_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_GATES         = 2,
  parameter int CAPACITY          = 7,
  parameter bit SENSOR_ACTIVE_LOW = 1'b0,
  localparam int CNT_W            = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] sensor_a,
  input  logic [NUM_GATES-1:0] sensor_b,
  input  logic                 clr_err,
  output logic [CNT_W-1:0]     count,
  output logic [CNT_W-1:0]     free,
  output logic                 full,
  output logic                 empty,
  output logic                 ovf_err,
  output logic                 unf_err,
  output logic [NUM_GATES-1:0] entry_pulse,
  output logic [NUM_GATES-1:0] exit_pulse,
  output logic [NUM_GATES-1:0] gate_busy
);

  localparam int NET_W = CNT_W + $clog2(NUM_GATES) + 2;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_GATES; gi++) begin : g_gate
      parking_gate_fsm #(
        .SENSOR_ACTIVE_LOW(SENSOR_ACTIVE_LOW)
      ) u_gate (
        .clk        (clk),
        .reset      (reset),
        .sensor_a   (sensor_a[gi]),
        .sensor_b   (sensor_b[gi]),
        .entry_pulse(entry_pulse[gi]),
        .exit_pulse (exit_pulse[gi]),
        .gate_busy  (gate_busy[gi])
      );
    end
  endgenerate

  logic [CNT_W-1:0]        count_reg, count_next;
  logic [CNT_W-1:0]        free_reg;
  logic                    full_reg, empty_reg;
  logic                    ovf_reg, unf_reg;
  logic                    ovf_set, unf_set;
  logic signed [NET_W-1:0] net, raw;

  always_comb begin
    net = '0;
    for (int i = 0; i < NUM_GATES; i++) begin
      net = net + NET_W'(entry_pulse[i]) - NET_W'(exit_pulse[i]);
    end
    raw        = net + $signed(NET_W'(count_reg));
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    count_next = CNT_W'(raw);
    if (raw > $signed(NET_W'(CAPACITY))) begin
      count_next = CNT_W'(CAPACITY);
      ovf_set    = 1'b1;
    end else if (raw[NET_W-1]) begin
      count_next = '0;
      unf_set    = 1'b1;
    end
  end

  // Status flags derive from count_next so they change on the same edge as count.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
      free_reg  <= CNT_W'(CAPACITY);
      full_reg  <= 1'b0;
      empty_reg <= 1'b1;
      ovf_reg   <= 1'b0;
      unf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      free_reg  <= CNT_W'(CAPACITY) - count_next;
      full_reg  <= (count_next == CNT_W'(CAPACITY));
      empty_reg <= (count_next == '0);
      ovf_reg   <= ovf_set | (ovf_reg & ~clr_err);
      unf_reg   <= unf_set | (unf_reg & ~clr_err);
    end
  end

  assign count   = count_reg;
  assign free    = free_reg;
  assign full    = full_reg;
  assign empty   = empty_reg;
  assign ovf_err = ovf_reg;
  assign unf_err = unf_reg;

endmodule

// File: tb/tb_parking_lot_ctrl.sv
// Directed bench: an active-high and an active-low instance run the same
// stimulus (inverted pins for the latter) and are checked against one table.
module tb_parking_lot_ctrl;

  localparam int OP_ENTRY = 0;
  localparam int OP_EXIT  = 1;
  localparam int OP_CLR   = 2;
  localparam int NVEC     = 22;

  typedef struct {
    int gate;
    int op;
    int exp_cnt;
    bit exp_ovf;
    bit exp_unf;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clr_err = 1'b0;
  logic [1:0] sa = 2'b00;
  logic [1:0] sb = 2'b00;

  logic [2:0] count0, free0, count1, free1;
  logic       full0, empty0, ovf0, unf0, full1, empty1, ovf1, unf1;
  logic [1:0] ent0, ext0, busy0, ent1, ext1, busy1;

  int nvec = 0;
  int nfail = 0;
  int ent_cnt[2][2];
  int ext_cnt[2][2];
  int exp_ent[2];
  int exp_ext[2];
  vec_t vecs[NVEC];

  always #5 clk = ~clk;

  parking_lot_ctrl #(.NUM_GATES(2), .CAPACITY(7), .SENSOR_ACTIVE_LOW(1'b0)) dut0 (
    .clk(clk), .reset(reset), .sensor_a(sa), .sensor_b(sb), .clr_err(clr_err),
    .count(count0), .free(free0), .full(full0), .empty(empty0),
    .ovf_err(ovf0), .unf_err(unf0),
    .entry_pulse(ent0), .exit_pulse(ext0), .gate_busy(busy0)
  );

  parking_lot_ctrl #(.NUM_GATES(2), .CAPACITY(7), .SENSOR_ACTIVE_LOW(1'b1)) dut1 (
    .clk(clk), .reset(reset), .sensor_a(~sa), .sensor_b(~sb), .clr_err(clr_err),
    .count(count1), .free(free1), .full(full1), .empty(empty1),
    .ovf_err(ovf1), .unf_err(unf1),
    .entry_pulse(ent1), .exit_pulse(ext1), .gate_busy(busy1)
  );

  initial begin
    for (int d = 0; d < 2; d++)
      for (int g = 0; g < 2; g++) begin
        ent_cnt[d][g] = 0;
        ext_cnt[d][g] = 0;
      end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      ent_cnt[0][g] += int'(ent0[g]);
      ext_cnt[0][g] += int'(ext0[g]);
      ent_cnt[1][g] += int'(ent1[g]);
      ext_cnt[1][g] += int'(ext1[g]);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete within time limit");
    $fatal(1, "watchdog");
  end

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {count, free, full, empty, ovf, unf} for both instances
  task automatic check_status(input string name, input int c, input bit ovf, input bit unf);
    logic [15:0] exp, a0, a1;
    exp = 16'({3'(c), 3'(7 - c), (c == 7), (c == 0), ovf, unf});
    a0  = 16'({count0, free0, full0, empty0, ovf0, unf0});
    a1  = 16'({count1, free1, full1, empty1, ovf1, unf1});
    cmp({name, "/status_al0"}, a0, exp);
    cmp({name, "/status_al1"}, a1, exp);
  endtask

  task automatic check_pulses(input string name);
    for (int d = 0; d < 2; d++)
      for (int g = 0; g < 2; g++) begin
        cmp($sformatf("%s/entries_d%0d_g%0d", name, d, g), 16'(ent_cnt[d][g]), 16'(exp_ent[g]));
        cmp($sformatf("%s/exits_d%0d_g%0d", name, d, g), 16'(ext_cnt[d][g]), 16'(exp_ext[g]));
      end
  endtask

  task automatic check_busy(input string name, input logic [1:0] exp);
    cmp({name, "/busy_al0"}, 16'(busy0), 16'(exp));
    cmp({name, "/busy_al1"}, 16'(busy1), 16'(exp));
  endtask

  task automatic step(input int g, input logic [1:0] ab);
    sa[g] = ab[1];
    sb[g] = ab[0];
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    if (v.op == OP_ENTRY) begin
      step(v.gate, 2'b10); step(v.gate, 2'b11); step(v.gate, 2'b01); step(v.gate, 2'b00);
      exp_ent[v.gate]++;
    end else if (v.op == OP_EXIT) begin
      step(v.gate, 2'b01); step(v.gate, 2'b11); step(v.gate, 2'b10); step(v.gate, 2'b00);
      exp_ext[v.gate]++;
    end else begin
      clr_err = 1'b1;
      @(posedge clk);
      #1;
      clr_err = 1'b0;
    end
    settle();
    @(negedge clk);
    $display("vec %0d gate %0d op %0d -> count=%0d ovf=%0b unf=%0b (expect %0d %0b %0b)",
             i, v.gate, v.op, count0, ovf0, unf0, v.exp_cnt, v.exp_ovf, v.exp_unf);
    check_status($sformatf("vec%0d", i), v.exp_cnt, v.exp_ovf, v.exp_unf);
    check_pulses($sformatf("vec%0d", i));
  endtask

  initial begin
    exp_ent = '{0, 0};
    exp_ext = '{0, 0};
    vecs[0]  = '{1, OP_ENTRY, 2, 1'b0, 1'b0};
    vecs[1]  = '{0, OP_ENTRY, 3, 1'b0, 1'b0};
    vecs[2]  = '{1, OP_EXIT,  2, 1'b0, 1'b0};
    vecs[3]  = '{0, OP_EXIT,  1, 1'b0, 1'b0};
    vecs[4]  = '{0, OP_ENTRY, 2, 1'b0, 1'b0};
    vecs[5]  = '{1, OP_ENTRY, 3, 1'b0, 1'b0};
    vecs[6]  = '{0, OP_ENTRY, 4, 1'b0, 1'b0};
    vecs[7]  = '{1, OP_ENTRY, 5, 1'b0, 1'b0};
    vecs[8]  = '{0, OP_ENTRY, 6, 1'b0, 1'b0};
    vecs[9]  = '{1, OP_ENTRY, 7, 1'b0, 1'b0};
    vecs[10] = '{0, OP_ENTRY, 7, 1'b1, 1'b0};
    vecs[11] = '{0, OP_CLR,   7, 1'b0, 1'b0};
    vecs[12] = '{0, OP_EXIT,  6, 1'b0, 1'b0};
    vecs[13] = '{1, OP_EXIT,  5, 1'b0, 1'b0};
    vecs[14] = '{0, OP_EXIT,  4, 1'b0, 1'b0};
    vecs[15] = '{1, OP_EXIT,  3, 1'b0, 1'b0};
    vecs[16] = '{0, OP_EXIT,  2, 1'b0, 1'b0};
    vecs[17] = '{1, OP_EXIT,  1, 1'b0, 1'b0};
    vecs[18] = '{0, OP_EXIT,  0, 1'b0, 1'b0};
    vecs[19] = '{1, OP_EXIT,  0, 1'b0, 1'b1};
    vecs[20] = '{0, OP_CLR,   0, 1'b0, 1'b0};
    vecs[21] = '{0, OP_ENTRY, 1, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    $display("reset: count=%0d free=%0d empty=%0b", count0, free0, empty0);
    check_status("reset", 0, 1'b0, 1'b0);
    check_busy("reset", 2'b00);
    cmp("reset/pulses_al0", 16'({ent0, ext0}), 16'h0);
    cmp("reset/pulses_al1", 16'({ent1, ext1}), 16'h0);

    // First entry on gate 0 with exact pulse/count latency
    step(0, 2'b10); step(0, 2'b11); step(0, 2'b01);
    sa[0] = 1'b0;
    sb[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("entry0 pulse edge: entry_pulse=%b count=%0d", ent0, count0);
    cmp("entry0/pulse_edge_al0", 16'({ent0, count0}), 16'({2'b01, 3'd0}));
    cmp("entry0/pulse_edge_al1", 16'({ent1, count1}), 16'({2'b01, 3'd0}));
    @(posedge clk);
    @(negedge clk);
    $display("entry0 count edge: entry_pulse=%b count=%0d", ent0, count0);
    cmp("entry0/count_edge_al0", 16'(ent0), 16'h0);
    cmp("entry0/count_edge_al1", 16'(ent1), 16'h0);
    exp_ent[0]++;
    check_status("entry0", 1, 1'b0, 1'b0);
    check_pulses("entry0");

    for (int i = 0; i < 12; i++) run_vec(i);

    // Entry on gate 0 and exit on gate 1 completing together at capacity
    sa = 2'b01; sb = 2'b10; @(posedge clk); #1;
    sa = 2'b11; sb = 2'b11; @(posedge clk); #1;
    sa = 2'b10; sb = 2'b01; @(posedge clk); #1;
    sa = 2'b00; sb = 2'b00;
    settle();
    @(negedge clk);
    exp_ent[0]++;
    exp_ext[1]++;
    $display("simultaneous at full: count=%0d ovf=%0b", count0, ovf0);
    check_status("simul", 7, 1'b0, 1'b0);
    check_pulses("simul");

    for (int i = 12; i < NVEC; i++) run_vec(i);

    // Aborted entry on gate 0
    step(0, 2'b10); step(0, 2'b11); step(0, 2'b10);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_busy("abort_mid", 2'b01);
    step(0, 2'b00);
    settle();
    @(negedge clk);
    $display("abort: count=%0d busy=%b", count0, busy0);
    check_status("abort", 1, 1'b0, 1'b0);
    check_busy("abort_end", 2'b00);
    check_pulses("abort");

    // Both beams at once from idle: parks in WAIT, no event
    step(1, 2'b11);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_busy("wait_mid", 2'b10);
    step(1, 2'b00);
    settle();
    @(negedge clk);
    $display("wait: count=%0d busy=%b", count0, busy0);
    check_status("wait", 1, 1'b0, 1'b0);
    check_busy("wait_end", 2'b00);
    check_pulses("wait");

    // Reset while gate 0 sits in EN_AB
    step(0, 2'b10); step(0, 2'b11);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_busy("rst_mid", 2'b01);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_busy("rst_release", 2'b00);
    step(0, 2'b01); step(0, 2'b00);
    settle();
    @(negedge clk);
    $display("reset mid-entry: count=%0d busy=%b", count0, busy0);
    check_status("rst_mid_entry", 0, 1'b0, 1'b0);
    check_busy("rst_end", 2'b00);
    check_pulses("rst_mid_entry");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
